// File: rtl/i6442_pkg.sv
// ----------------------------------------------------------------------------
// i6442_pkg
// Shared definitions for the test_i6442 run detector: the word width, the
// default run length that raises the output, and the tracker FSM state type.
// ----------------------------------------------------------------------------
package i6442_pkg;

  // Width of the sampled input word W = {N0,N1,N2}
  localparam int WORD_W = 3;

  // Default number of consecutive modulo-8 increments needed to flag a run
  localparam int RUN_TARGET_DEFAULT = 3;

  // IDLE: no previous word held yet; TRACK: prev holds a valid word
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

endpackage : i6442_pkg

// File: rtl/test_i6442_if.sv
// ----------------------------------------------------------------------------
// test_i6442_if
// Bundles the word bits and the run-detect flag of test_i6442 so an
// environment can drive and observe the block through one handle.
//   n0, n1, n2     : word bits, W = {n0,n1,n2} (n0 is the MSB)
//   output_single  : registered run-detect flag returned by the block
// Modports:
//   master : drives the word, observes the flag
//   slave  : receives the word, returns the flag
// ----------------------------------------------------------------------------
interface test_i6442_if;

  logic n0;
  logic n1;
  logic n2;
  logic output_single;

  modport master (
    output n0,
    output n1,
    output n2,
    input  output_single
  );

  modport slave (
    input  n0,
    input  n1,
    input  n2,
    output output_single
  );

endinterface : test_i6442_if

// File: rtl/i6442_run_counter.sv
// ----------------------------------------------------------------------------
// i6442_run_counter
// Saturating count of consecutive increments and the compare that decides
// whether the current increment completes a run of RUN_TARGET.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   inc    : the word sampled this edge is (prev + 1) mod 8
//   run    : registered increment count, saturates at RUN_TARGET
//   hit    : run (pre-edge) >= RUN_TARGET-1, i.e. one more increment
//            reaches the target
// ----------------------------------------------------------------------------
module i6442_run_counter
  import i6442_pkg::*;
#(
  parameter int RUN_TARGET = RUN_TARGET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [WORD_W-1:0] run,
  output logic              hit
);

  localparam logic [WORD_W-1:0] TARGET_C = WORD_W'(RUN_TARGET);

  logic [WORD_W-1:0] run_r;
  logic [WORD_W-1:0] run_nxt_s;
  logic              hit_s;

  // Next run value: saturating increment on inc, otherwise cleared
  always_comb begin
    run_nxt_s = {WORD_W{1'b0}};
    if (inc) begin
      if (run_r >= TARGET_C) begin
        run_nxt_s = TARGET_C;
      end else begin
        run_nxt_s = run_r + 3'd1;
      end
    end else begin
      run_nxt_s = {WORD_W{1'b0}};
    end
  end

  // Compare done one bit wider so run+1 cannot wrap when RUN_TARGET is 7
  always_comb begin
    hit_s = 1'b0;
    if (({1'b0, run_r} + 4'd1) >= {1'b0, TARGET_C}) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Run count register
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r <= {WORD_W{1'b0}};
    end else begin
      run_r <= run_nxt_s;
    end
  end

  assign run = run_r;
  assign hit = hit_s;

endmodule : i6442_run_counter

// File: rtl/test_i6442.sv
// ----------------------------------------------------------------------------
// test_i6442
// Modulo-8 run detector. Every rising CK samples W = {N0,N1,N2}. When W is
// the previous word plus one (mod 8, so 7 -> 0 counts) for RUN_TARGET edges
// in a row, output_single goes high one clock after the completing word and
// stays high while the increments continue. Any other word, including a
// repeat, clears the run and the flag at that edge.
//   N0, N1, N2     : word bits, N0 is the MSB
//   CK             : clock, rising edge
//   reset          : synchronous active-high reset, wins over an increment
//   output_single  : registered run-detect flag
// ----------------------------------------------------------------------------
module test_i6442
  import i6442_pkg::*;
#(
  parameter int RUN_TARGET = RUN_TARGET_DEFAULT
) (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic CK,
  input  logic reset,
  output logic output_single
);

  logic [WORD_W-1:0] word_s;
  logic [WORD_W-1:0] prev_r;
  state_e            state_r;
  state_e            state_nxt_s;
  logic              valid_s;
  logic              inc_s;
  logic              hit_s;
  logic [WORD_W-1:0] run_s;
  logic              out_r;

  assign word_s = {N0, N1, N2};

  // Tracker FSM state register
  always_ff @(posedge CK) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Tracker FSM next state and the valid/increment decode
  always_comb begin
    state_nxt_s = IDLE;
    valid_s     = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // First word after reset only loads prev
        state_nxt_s = TRACK;
        valid_s     = 1'b0;
        inc_s       = 1'b0;
      end
      TRACK: begin
        state_nxt_s = TRACK;
        valid_s     = 1'b1;
        if (word_s == (prev_r + 3'd1)) begin
          inc_s = 1'b1;
        end else begin
          inc_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_s     = 1'b0;
        inc_s       = 1'b0;
      end
    endcase
  end

  // Previous-word register
  always_ff @(posedge CK) begin
    if (reset) begin
      prev_r <= {WORD_W{1'b0}};
    end else begin
      prev_r <= word_s;
    end
  end

  i6442_run_counter #(
    .RUN_TARGET (RUN_TARGET)
  ) u_run_counter (
    .clk   (CK),
    .reset (reset),
    .inc   (inc_s),
    .run   (run_s),
    .hit   (hit_s)
  );

  // Output flag register, uses the pre-edge run through hit_s
  always_ff @(posedge CK) begin
    if (reset) begin
      out_r <= 1'b0;
    end else begin
      out_r <= inc_s & hit_s;
    end
  end

  assign output_single = out_r;

  // valid_s and run_s are kept visible for debug probing
  logic unused_s;
  assign unused_s = valid_s ^ (^run_s);

endmodule : test_i6442

// File: tb/tb_test_i6442.sv
// ----------------------------------------------------------------------------
// tb_test_i6442
// Directed vector table and randomized stimulus for test_i6442, with a
// streak-length reference model. A second instance with RUN_TARGET=1 shares
// the stimulus.
// ----------------------------------------------------------------------------
module tb_test_i6442;

  logic CK;
  logic reset;
  logic out1;

  test_i6442_if bus ();

  test_i6442 #(.RUN_TARGET(3)) dut3 (
    .N0            (bus.n0),
    .N1            (bus.n1),
    .N2            (bus.n2),
    .CK            (CK),
    .reset         (reset),
    .output_single (bus.output_single)
  );

  test_i6442 #(.RUN_TARGET(1)) dut1 (
    .N0            (bus.n0),
    .N1            (bus.n1),
    .N2            (bus.n2),
    .CK            (CK),
    .reset         (reset),
    .output_single (out1)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic       rst;
    logic [2:0] w;
    logic       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   passed;

  // Reference model state: last word, whether it is valid, streak length
  logic [2:0] m_prev;
  logic       m_valid;
  int         m_streak;

  function automatic void add(input logic r, input logic [2:0] w, input logic e);
    vec_t v;
    v.rst = r;
    v.w   = w;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [2:0] w);
    @(negedge CK);
    reset  = r;
    bus.n0 = w[2];
    bus.n1 = w[1];
    bus.n2 = w[0];
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Model: a streak is the number of consecutive +1 (mod 8) words seen
  task automatic model_step(input logic r, input logic [2:0] w,
                            output logic e3, output logic e1);
    logic inc;
    if (r) begin
      m_prev = 3'd0; m_valid = 1'b0; m_streak = 0;
      e3 = 1'b0; e1 = 1'b0;
    end else begin
      inc = m_valid && (int'(w) == ((int'(m_prev) + 1) % 8));
      m_streak = inc ? m_streak + 1 : 0;
      e3 = inc && (m_streak >= 3);
      e1 = inc && (m_streak >= 1);
      m_prev = w;
      m_valid = 1'b1;
    end
  endtask

  initial begin
    logic [2:0] w;
    logic       r;
    logic       e3;
    logic       e1;
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    bus.n0 = 1'b0; bus.n1 = 1'b0; bus.n2 = 1'b0;

    // 0..7 ramp
    add(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 3'(i), (i >= 3) ? 1'b1 : 1'b0);
    // 7 -> 0 wrap counts
    add(1'b1, 3'd0, 1'b0);
    add(1'b0, 3'd6, 1'b0); add(1'b0, 3'd7, 1'b0);
    add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd1, 1'b1);
    // repeated word clears the run
    add(1'b1, 3'd0, 1'b0);
    add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd1, 1'b0); add(1'b0, 3'd2, 1'b0);
    add(1'b0, 3'd2, 1'b0); add(1'b0, 3'd3, 1'b0); add(1'b0, 3'd4, 1'b0);
    add(1'b0, 3'd5, 1'b1);
    // reset mid-run wins over the increment
    add(1'b1, 3'd0, 1'b0);
    add(1'b0, 3'd0, 1'b0); add(1'b0, 3'd1, 1'b0); add(1'b0, 3'd2, 1'b0);
    add(1'b0, 3'd3, 1'b1);
    add(1'b1, 3'd4, 1'b0);
    add(1'b0, 3'd5, 1'b0); add(1'b0, 3'd6, 1'b0); add(1'b0, 3'd7, 1'b0);
    add(1'b0, 3'd0, 1'b1);
    // constant word never flags
    add(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 3'd5, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].w);
      check($sformatf("vec%0d_w%0d", i, vecs[i].w), bus.output_single, vecs[i].exp);
    end

    // RUN_TARGET=1 instance: 3,4,6,7 -> 0,1,0,1
    step(1'b1, 3'd0);
    check("t1_reset", out1, 1'b0);
    step(1'b0, 3'd3); check("t1_w3", out1, 1'b0);
    step(1'b0, 3'd4); check("t1_w4", out1, 1'b1);
    step(1'b0, 3'd6); check("t1_w6", out1, 1'b0);
    step(1'b0, 3'd7); check("t1_w7", out1, 1'b1);

    // Randomized run: bias toward increments so long runs saturate
    step(1'b1, 3'd0);
    model_step(1'b1, 3'd0, e3, e1);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      if (m_valid && ($urandom_range(0, 3) != 0)) begin
        w = m_prev + 3'd1;
      end else begin
        w = 3'($urandom_range(0, 7));
      end
      step(r, w);
      model_step(r, w, e3, e1);
      check($sformatf("rnd%0d_t3", i), bus.output_single, e3);
      check($sformatf("rnd%0d_t1", i), out1, e1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_test_i6442
